// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS word registers with byte-strobed writes,
// independent AW/W capture, 1-cycle registered reads and per-register write pulses.
module axil_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [BE_WIDTH-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [BE_WIDTH-1:0]   w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // Readies depend only on registered state.
  assign s_axi_awready = !aw_held_q && !bvalid_q;
  assign s_axi_wready  = !w_held_q && !bvalid_q;
  assign s_axi_arready = !rvalid_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  // A held channel takes precedence; otherwise the one handshaking this cycle.
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;

  assign wr_in_range = (wr_addr >> (IDX_W + 2)) == '0;
  assign rd_in_range = (s_axi_araddr >> (IDX_W + 2)) == '0;
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign rd_idx      = s_axi_araddr[IDX_W+1:2];

  always_comb begin
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end

    if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RespOkay : RespSlvErr;
      if (wr_in_range) begin
        wr_pulse_d[wr_idx] = 1'b1;
        for (int unsigned b = 0; b < BE_WIDTH; b++) begin
          if (wr_strb[b]) begin
            regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end

    // regs_q here is the pre-commit value, so a same-edge read sees old data.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? regs_q[rd_idx] : '0;
      rresp_d  = rd_in_range ? RespOkay : RespSlvErr;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      regs_q     <= '{default: '0};
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign wr_pulse     = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, AXI-Lite byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; BE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_REGS, default 16, power of two, 2..256; IDX_W = clog2(NUM_REGS).
REQ-004 SHALL have ports:
- clk, in, 1: clock; all logic on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- s_axi_awaddr, in, ADDR_WIDTH: write address.
- s_axi_awvalid, in, 1; s_axi_awready, out, 1.
- s_axi_wdata, in, DATA_WIDTH; s_axi_wstrb, in, BE_WIDTH.
- s_axi_wvalid, in, 1; s_axi_wready, out, 1.
- s_axi_bresp, out, 2; s_axi_bvalid, out, 1; s_axi_bready, in, 1.
- s_axi_araddr, in, ADDR_WIDTH; s_axi_arvalid, in, 1; s_axi_arready, out, 1.
- s_axi_rdata, out, DATA_WIDTH; s_axi_rresp, out, 2; s_axi_rvalid, out, 1; s_axi_rready, in, 1.
- regs_out, out, NUM_REGS*DATA_WIDTH: register file contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse, out, NUM_REGS: one-cycle pulse on bit i when reg i is written.

Function
REQ-005 SHALL decode address: idx = addr[IDX_W+1:2]; addr[1:0] ignored; in-range iff addr[ADDR_WIDTH-1:IDX_W+2] == 0.
REQ-006 SHALL drive awready = !aw_held && !bvalid and wready = !w_held && !bvalid, from registered state only (no input-to-ready combinational path).
REQ-007 SHALL capture AW and W independently, in either order or the same cycle; a captured channel sets aw_held/w_held and holds addr/data/strb.
REQ-008 SHALL commit the write on the edge where both AW and W are available (held or handshaking that cycle): per-byte update of reg idx where wstrb bit set; clear aw_held, w_held; set bvalid.
REQ-009 SHALL, on commit to out-of-range address, leave all regs unchanged, assert no wr_pulse, set bresp = 2'b10 (SLVERR); in-range sets bresp = 2'b00.
REQ-010 SHALL pulse wr_pulse[idx] high for exactly the cycle after commit (registered), even if wstrb = 0.
REQ-011 SHALL hold bvalid and bresp stable until bvalid && bready; bvalid clears on that edge; awready/wready reassert the following cycle.
REQ-012 SHALL drive arready = !rvalid (registered state only).
REQ-013 SHALL, on arvalid && arready, register rdata = reg[idx] (in-range) or 0 (out-of-range), rresp = 2'b00 or 2'b10, and set rvalid the next cycle (1-cycle latency).
REQ-014 SHALL hold rvalid, rdata, rresp stable until rvalid && rready; rvalid clears on that edge.
REQ-015 SHALL run read and write paths independently and concurrently; a read capturing the same register on the commit edge returns the pre-write value.
REQ-016 SHALL support back-to-back transactions at one per 2 cycles per channel with bready/rready tied high.
REQ-017 SHALL update regs_out on the commit edge (visible the cycle after commit).

Reset
REQ-018 SHALL, while rst_n = 0 at a clock edge, clear all regs to 0, aw_held, w_held, bvalid, rvalid, wr_pulse to 0, bresp, rresp, rdata to 0.
REQ-019 SHALL drop in-flight transactions on reset mid-operation (held AW/W discarded, pending B/R responses withdrawn); awready, wready, arready = 1 the first cycle after reset release.

Verification
REQ-020 SHALL cover: AW and W same cycle, addr 0x0008, data 0xDEADBEEF, wstrb 0xF -> next cycle bvalid = 1, bresp = 00, wr_pulse[2] = 1, regs_out reg2 = 0xDEADBEEF.
REQ-021 SHALL cover: W sent 3 cycles before AW (addr 0x0004, data 0x11223344, wstrb 0x5) over reg1 = 0xFFFFFFFF -> reg1 = 0xFF22FF44, single bvalid, wready low after W captured.
REQ-022 SHALL cover: write addr 0x0040 (NUM_REGS=16) -> bresp = 10, no wr_pulse, regs unchanged; read 0x0040 -> rdata = 0, rresp = 10.
REQ-023 SHALL cover: bready held low 5 cycles after commit -> bvalid/bresp stable, awready and wready low throughout; next write accepted after handshake.
REQ-024 SHALL cover: read of reg3 (=0x0) captured on same edge as write commit of 0xA5A5A5A5 to reg3 -> rdata = 0x0; subsequent read -> 0xA5A5A5A5.
REQ-025 SHALL cover: rst_n low while aw_held = 1 and rvalid = 1 -> after release bvalid = rvalid = 0, all regs 0, all readies 1, no spurious write.
